fdl_lock_ctrl: RTL and testbench
================================

Name: fdl_lock_ctrl

Overview:
- Closed-loop controller for the 6-tap fine delay line (FDL) in the FMDLL.
- Samples phase-detector up/down decisions and steps the FDL load-enable thermometer code Q[5:0] one tap at a time.
- Hands carries and borrows to the coarse delay line via single-cycle inc/dec pulses.
- Waits a programmable settle time after each step, and detects lock and loss of lock from the step-direction history.

Parameters:
- INIT_CODE, 3: number of FDL taps enabled after reset (0..6).
- SETTLE_CYC, 8: wait cycles after each step before the next sample (1..255).
- LOCK_REV, 4: consecutive direction reversals required to assert locked (1..15).
- UNLOCK_RUN, 6: consecutive same-direction steps that clear locked (2..15).

Ports:
- clk_in  input  1  controller clock (DLL reference clock).
- rst  input  1  asynchronous, active-high reset.
- en  input  1  loop enable.
- pd_up  input  1  phase detector: output early, add delay.
- pd_dn  input  1  phase detector: output late, remove delay.
- cdl_max  input  1  coarse line at maximum setting.
- cdl_min  input  1  coarse line at minimum setting.
- fdl_q  output  6  FDL thermometer code; bit i enables load i.
- cdl_inc  output  1  one-cycle pulse: coarse line +1 step.
- cdl_dec  output  1  one-cycle pulse: coarse line -1 step.
- locked  output  1  loop locked.
- at_limit  output  1  a step was blocked by a range end.

Behaviour:
- Reset and clocking:
  - One clock (clk_in). rst is asynchronous and active-high.
  - Tap count n is held in a 3-bit register. fdl_q = (1<<n)-1, so fdl_q[i] = (i < n).
  - On reset: n = INIT_CODE (fdl_q = 6'b000111 at default), cdl_inc = 0, cdl_dec = 0, locked = 0, at_limit = 0, state = IDLE, all counters = 0, last direction = none.
  - Reset asserted mid-settle or mid-step aborts immediately. No coarse pulse is emitted.
- FSM states: IDLE, SAMPLE, SETTLE.
  - IDLE: if en = 1, go to SAMPLE next cycle. fdl_q holds its value.
  - SAMPLE: evaluates pd_up/pd_dn in that cycle.
    - Exactly one of them high: a step is taken and the state goes to SETTLE.
    - Both or neither high: no step, stay in SAMPLE. Counters and last direction are unchanged.
  - SETTLE: counts SETTLE_CYC cycles, then returns to SAMPLE. pd inputs are ignored.
  - en = 0 in any state: go to IDLE next cycle and clear locked. n, the counters and at_limit hold. A step decided in the same cycle still completes.
- Step rules (registered; fdl_q and pulses appear on the clock edge after the SAMPLE cycle):
  - Up, n < 6: n = n + 1.
  - Up, n = 6, cdl_max = 0: n = 0 and cdl_inc = 1 for one cycle (carry).
  - Up, n = 6, cdl_max = 1: n holds at 6 and at_limit is set.
  - Down, n > 0: n = n - 1.
  - Down, n = 0, cdl_min = 0: n = 6 and cdl_dec = 1 for one cycle (borrow).
  - Down, n = 0, cdl_min = 1: n holds at 0 and at_limit is set.
  - at_limit clears on the next step that is not blocked.
  - A blocked step still enters SETTLE and still updates direction history.
  - cdl_inc and cdl_dec are never high together and are never high on consecutive cycles.
- Lock detection:
  - last_dir is recorded on every step.
  - Step opposite to last_dir: rev_cnt increments (saturating at 15) and run_cnt = 1.
  - Step in the same direction as last_dir: run_cnt increments (saturating) and rev_cnt = 0.
  - The first step after reset or after IDLE sets only last_dir and run_cnt = 1.
  - locked is set on the edge after the step on which rev_cnt reaches LOCK_REV.
  - locked is cleared on the edge after the step on which run_cnt reaches UNLOCK_RUN.
  - Tracking continues while locked.
- Timing:
  - Minimum step-to-step spacing is SETTLE_CYC + 1 cycles.
  - Latency from the SAMPLE cycle to a visible fdl_q change is 1 cycle.

Test Plan:
- Reset: assert rst mid-SETTLE with n = 5 -> fdl_q = 6'b000111 immediately, no cdl pulse, locked = 0.
- Steady up: en = 1, pd_up = 1 held from n = 3 -> fdl_q steps 0F, 1F, 3F, then 00 with cdl_inc pulsed one cycle. Steps are spaced SETTLE_CYC + 1 = 9 cycles.
- Borrow at zero: n = 0, pd_dn = 1, cdl_min = 0 -> fdl_q = 3F with cdl_dec pulsed one cycle. Repeat with cdl_min = 1 -> fdl_q stays 00, at_limit = 1, no pulse.
- Lock: alternate pd_up and pd_dn on each SAMPLE -> locked rises after the 5th step (4 reversals). Then 6 consecutive pd_up steps -> locked falls after the 6th.
- Invalid PD: pd_up = pd_dn = 1 for 20 cycles in SAMPLE -> fdl_q is unchanged, no SETTLE entry, counters unchanged.
- Disable: drop en while locked -> IDLE next cycle, locked = 0, fdl_q holds. Re-enable -> sampling resumes from the held code.

Source files
------------

// File: rtl/fdl_lock_ctrl_if.sv
// Control/status bundle between the FMDLL phase detector, coarse line and the
// fine-delay-line lock controller.
interface fdl_lock_ctrl_if;
    logic       en;
    logic       pd_up;
    logic       pd_dn;
    logic       cdl_max;
    logic       cdl_min;
    logic [5:0] fdl_q;
    logic       cdl_inc;
    logic       cdl_dec;
    logic       locked;
    logic       at_limit;

    modport master (
        output en, pd_up, pd_dn, cdl_max, cdl_min,
        input  fdl_q, cdl_inc, cdl_dec, locked, at_limit
    );

    modport slave (
        input  en, pd_up, pd_dn, cdl_max, cdl_min,
        output fdl_q, cdl_inc, cdl_dec, locked, at_limit
    );
endinterface

// File: rtl/fdl_lock_ctrl.sv
// Fine delay line lock controller: steps a 6-tap thermometer code from phase
// detector decisions, carries/borrows into the coarse line and tracks lock.
module fdl_lock_ctrl #(
    parameter int INIT_CODE  = 3,
    parameter int SETTLE_CYC = 8,
    parameter int LOCK_REV   = 4,
    parameter int UNLOCK_RUN = 6
) (
    input  logic          clk_in,
    input  logic          rst,
    fdl_lock_ctrl_if.slave bus
);

    localparam logic [2:0] LP_INIT        = 3'(INIT_CODE);
    localparam logic [7:0] LP_SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [3:0] LP_LOCK_REV    = 4'(LOCK_REV);
    localparam logic [3:0] LP_UNLOCK_RUN  = 4'(UNLOCK_RUN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    function automatic logic [5:0] therm(input logic [2:0] n);
        logic [5:0] q;
        case (n)
            3'd0:    q = 6'h00;
            3'd1:    q = 6'h01;
            3'd2:    q = 6'h03;
            3'd3:    q = 6'h07;
            3'd4:    q = 6'h0F;
            3'd5:    q = 6'h1F;
            3'd6:    q = 6'h3F;
            default: q = 6'h3F;
        endcase
        return q;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    state_t     r_state;
    dir_t       r_last_dir;
    logic [2:0] r_n;
    logic [5:0] r_fdl_q;
    logic [7:0] r_settle_cnt;
    logic [3:0] r_rev_cnt;
    logic [3:0] r_run_cnt;
    logic       r_inc;
    logic       r_dec;
    logic       r_locked;
    logic       r_at_limit;

    logic       w_step;
    logic [2:0] w_n_next;
    logic       w_carry;
    logic       w_borrow;
    logic       w_blocked;
    dir_t       w_dir;
    logic [3:0] w_rev_next;
    logic [3:0] w_run_next;
    logic       w_lock_set;
    logic       w_lock_clr;

    // Next tap count and coarse-line handoff for a step taken this cycle
    always_comb begin
        w_step    = (r_state == ST_SAMPLE) && (bus.pd_up ^ bus.pd_dn);
        w_n_next  = r_n;
        w_carry   = 1'b0;
        w_borrow  = 1'b0;
        w_blocked = 1'b0;
        if (bus.pd_up) begin
            if (r_n < 3'd6) begin
                w_n_next = r_n + 3'd1;
            end else if (!bus.cdl_max) begin
                w_n_next = 3'd0;
                w_carry  = 1'b1;
            end else begin
                w_blocked = 1'b1;
            end
        end else begin
            if (r_n > 3'd0) begin
                w_n_next = r_n - 3'd1;
            end else if (!bus.cdl_min) begin
                w_n_next = 3'd6;
                w_borrow = 1'b1;
            end else begin
                w_blocked = 1'b1;
            end
        end
    end

    // Direction history: reversals build lock, long same-direction runs break it
    always_comb begin
        w_dir      = bus.pd_up ? DIR_UP : DIR_DN;
        w_rev_next = r_rev_cnt;
        w_run_next = r_run_cnt;
        w_lock_set = 1'b0;
        w_lock_clr = 1'b0;
        if (r_last_dir == DIR_NONE) begin
            w_run_next = 4'd1;
        end else if (w_dir != r_last_dir) begin
            w_rev_next = sat_inc(r_rev_cnt);
            w_run_next = 4'd1;
            w_lock_set = (w_rev_next >= LP_LOCK_REV);
        end else begin
            w_run_next = sat_inc(r_run_cnt);
            w_rev_next = 4'd0;
            w_lock_clr = (w_run_next >= LP_UNLOCK_RUN);
        end
    end

    // Control FSM with registered code, pulses and status
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_dir   <= DIR_NONE;
            r_n          <= LP_INIT;
            r_fdl_q      <= therm(LP_INIT);
            r_settle_cnt <= 8'd0;
            r_rev_cnt    <= 4'd0;
            r_run_cnt    <= 4'd0;
            r_inc        <= 1'b0;
            r_dec        <= 1'b0;
            r_locked     <= 1'b0;
            r_at_limit   <= 1'b0;
        end else begin
            r_inc <= 1'b0;
            r_dec <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= bus.en ? ST_SAMPLE : ST_IDLE;
                end
                ST_SAMPLE: begin
                    if (w_step) begin
                        r_n          <= w_n_next;
                        r_fdl_q      <= therm(w_n_next);
                        r_inc        <= w_carry;
                        r_dec        <= w_borrow;
                        r_at_limit   <= w_blocked;
                        r_last_dir   <= w_dir;
                        r_rev_cnt    <= w_rev_next;
                        r_run_cnt    <= w_run_next;
                        r_settle_cnt <= 8'd0;
                        r_state      <= ST_SETTLE;
                        if (w_lock_set) begin
                            r_locked <= 1'b1;
                        end else if (w_lock_clr) begin
                            r_locked <= 1'b0;
                        end else begin
                            r_locked <= r_locked;
                        end
                    end else begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == LP_SETTLE_LAST) begin
                        r_settle_cnt <= 8'd0;
                        r_state      <= ST_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // Disable wins over any transition; an in-flight step has already been applied above
            if (!bus.en) begin
                r_state    <= ST_IDLE;
                r_locked   <= 1'b0;
                r_last_dir <= DIR_NONE;
            end
        end
    end

    assign bus.fdl_q    = r_fdl_q;
    assign bus.cdl_inc  = r_inc;
    assign bus.cdl_dec  = r_dec;
    assign bus.locked   = r_locked;
    assign bus.at_limit = r_at_limit;

endmodule

// File: tb/tb_fdl_lock_ctrl.sv
// Randomized bench for fdl_lock_ctrl against a cycle-level behavioural model
// of the tap count, settle timing and lock history.
module tb_fdl_lock_ctrl;

    localparam int INIT_CODE  = 3;
    localparam int SETTLE_CYC = 8;
    localparam int LOCK_REV   = 4;
    localparam int UNLOCK_RUN = 6;

    localparam int M_RND = 0, M_UP = 1, M_DN = 2, M_ALT = 3, M_BAD = 4;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    fdl_lock_ctrl_if u_if ();

    fdl_lock_ctrl #(
        .INIT_CODE (INIT_CODE),
        .SETTLE_CYC(SETTLE_CYC),
        .LOCK_REV  (LOCK_REV),
        .UNLOCK_RUN(UNLOCK_RUN)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (u_if)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_n, m_wait, m_rev, m_run, m_last;   // m_last: 0 none, 1 up, 2 down
    bit m_active, m_locked, m_limit, m_inc, m_dec;
    bit lock_seen, unlock_seen, prev_pulse;
    int mode;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = INIT_CODE; m_wait = 0; m_rev = 0; m_run = 0; m_last = 0;
        m_active = 0; m_locked = 0; m_limit = 0; m_inc = 0; m_dec = 0;
    endtask

    task automatic model_step(input bit up);
        bit blocked;
        int dir;
        blocked = 0;
        dir = up ? 1 : 2;
        if (up) begin
            if (m_n < 6) m_n++;
            else if (!u_if.cdl_max) begin m_n = 0; m_inc = 1; end
            else blocked = 1;
        end else begin
            if (m_n > 0) m_n--;
            else if (!u_if.cdl_min) begin m_n = 6; m_dec = 1; end
            else blocked = 1;
        end
        m_limit = blocked;
        if (m_last == 0) begin
            m_run = 1;
        end else if (dir != m_last) begin
            m_rev = (m_rev >= 15) ? 15 : m_rev + 1;
            m_run = 1;
            if (m_rev >= LOCK_REV) m_locked = 1;
        end else begin
            m_run = (m_run >= 15) ? 15 : m_run + 1;
            m_rev = 0;
            if (m_run >= UNLOCK_RUN) m_locked = 0;
        end
        m_last = dir;
    endtask

    task automatic model_update();
        m_inc = 0;
        m_dec = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (!m_active) begin
                if (u_if.en) begin m_active = 1; m_wait = 0; end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (u_if.pd_up != u_if.pd_dn) begin
                model_step(u_if.pd_up);
                m_wait = SETTLE_CYC;
            end
            if (!u_if.en) begin
                m_active = 0; m_locked = 0; m_last = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [5:0] exp_q;
        bit pulse;
        exp_q = 6'((1 << m_n) - 1);
        check_eq("fdl_q",    8'(u_if.fdl_q),    8'(exp_q));
        check_eq("cdl_inc",  8'(u_if.cdl_inc),  8'(m_inc));
        check_eq("cdl_dec",  8'(u_if.cdl_dec),  8'(m_dec));
        check_eq("locked",   8'(u_if.locked),   8'(m_locked));
        check_eq("at_limit", 8'(u_if.at_limit), 8'(m_limit));
        pulse = u_if.cdl_inc | u_if.cdl_dec;
        check_eq("pulse_both", 8'(u_if.cdl_inc & u_if.cdl_dec), 8'd0);
        check_eq("pulse_consec", 8'(prev_pulse & pulse), 8'd0);
        prev_pulse = pulse;
        if (u_if.locked) lock_seen = 1;
        if (lock_seen && !u_if.locked && u_if.en) unlock_seen = 1;
    endtask

    task automatic drive_pd();
        case (mode)
            M_UP:  begin u_if.pd_up = 1'b1; u_if.pd_dn = 1'b0; end
            M_DN:  begin u_if.pd_up = 1'b0; u_if.pd_dn = 1'b1; end
            M_ALT: begin u_if.pd_up = (m_last != 1); u_if.pd_dn = (m_last == 1); end
            M_BAD: begin u_if.pd_up = 1'b1; u_if.pd_dn = 1'b1; end
            default: begin u_if.pd_up = 1'($urandom); u_if.pd_dn = 1'($urandom); end
        endcase
    endtask

    task automatic run_cycle();
        @(posedge clk_in);
        model_update();
        #1;
        compare_all();
        drive_pd();
    endtask

    initial begin
        model_reset();
        prev_pulse = 0; lock_seen = 0; unlock_seen = 0;
        mode = M_UP;
        u_if.en = 1'b0; u_if.pd_up = 1'b0; u_if.pd_dn = 1'b0;
        u_if.cdl_max = 1'b0; u_if.cdl_min = 1'b0;
        repeat (3) run_cycle();
        rst = 1'b0;
        run_cycle();

        // climb to n = 5 and reset in the middle of the settle window
        u_if.en = 1'b1;
        u_if.pd_up = 1'b1;
        repeat (15) run_cycle();
        check_eq("pre_rst_n5", 8'(u_if.fdl_q), 8'h1F);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_fdl_q", 8'(u_if.fdl_q), 8'h07);
        check_eq("rst_inc", 8'(u_if.cdl_inc | u_if.cdl_dec), 8'd0);
        check_eq("rst_locked", 8'(u_if.locked), 8'd0);
        repeat (2) run_cycle();
        rst = 1'b0;

        // fixed phases: up carry, borrow, blocked borrow, lock/unlock, invalid PD,
        // disable, then randomized phases
        for (int ph = 0; ph < 40; ph++) begin
            u_if.en = 1'b1;
            case (ph)
                0: begin mode = M_UP;  u_if.cdl_max = 1'b0; end
                1: begin mode = M_DN;  u_if.cdl_min = 1'b0; end
                2: begin mode = M_DN;  u_if.cdl_min = 1'b1; end
                3: begin mode = M_ALT; end
                4: begin mode = M_UP;  u_if.cdl_max = 1'b1; end
                5: begin mode = M_ALT; end
                6: begin mode = M_BAD; end
                7: begin mode = M_ALT; u_if.en = 1'b0; end
                default: begin
                    mode = int'($urandom_range(4, 0));
                    u_if.en = ($urandom_range(9, 0) != 0);
                    u_if.cdl_max = 1'($urandom);
                    u_if.cdl_min = 1'($urandom);
                end
            endcase
            drive_pd();
            repeat (100) run_cycle();
        end

        check_eq("lock_seen", 8'(lock_seen), 8'd1);
        check_eq("unlock_seen", 8'(unlock_seen), 8'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
